// File: rtl/instr_loader.sv
// Byte-stream to instruction-word loader: LSB-first assembler feeding a first-word-fall-through FIFO.
// Optional partial-word idle timeout is enabled by defining INSTR_LOADER_TIMEOUT_EN.
module instr_loader #(
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    input  logic                       flush,
    output logic [INSTR_W-1:0]         instr_o,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       timeout_err
);
    localparam int NB    = INSTR_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    logic [IDX_W-1:0]   byte_idx_reg, byte_idx_next, lane_idx;
    logic [INSTR_W-1:0] partial_reg, partial_next, partial_base, assembled;
    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               overflow_reg, timeout_err_reg;
    logic               expire, word_done, pop, push, drop;

`ifdef INSTR_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] idle_reg;

    assign expire = (byte_idx_reg != '0) && (idle_reg == TO_W'(TIMEOUT));

    // Counts cycles without a byte while a word is partially assembled.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            idle_reg <= '0;
        end else if (rx_valid || byte_idx_next == '0) begin
            idle_reg <= '0;
        end else begin
            idle_reg <= idle_reg + TO_W'(1);
        end
    end
`else
    // Without the idle counter TIMEOUT has no effect; this is constant false.
    assign expire = (TIMEOUT < 0);
`endif

    // An expiring partial word is discarded, so a byte in that cycle lands in lane 0.
    assign lane_idx     = expire ? '0 : byte_idx_reg;
    assign partial_base = expire ? '0 : partial_reg;
    assign word_done    = rx_valid && (lane_idx == LAST_IDX);

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign assembled[8*gi +: 8] = (rx_valid && lane_idx == IDX_W'(gi))
                                        ? rx_data : partial_base[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_idx_next = lane_idx;
        partial_next  = partial_base;
        if (rx_valid) begin
            byte_idx_next = word_done ? '0 : lane_idx + IDX_W'(1);
            partial_next  = assembled;
        end
    end

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == CNT_W'(DEPTH));
    assign instr_valid = !empty;
    assign pop         = instr_valid && instr_ready;
    assign push        = word_done && (!full || pop);
    assign drop        = word_done && full && !pop;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            byte_idx_reg    <= '0;
            partial_reg     <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            overflow_reg    <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            byte_idx_reg <= byte_idx_next;
            partial_reg  <= partial_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
            if (drop)   overflow_reg    <= 1'b1;
            if (expire) timeout_err_reg <= 1'b1;
        end
    end

    // Storage carries no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem[wr_ptr_reg] <= assembled;
        end
    end

    assign instr_o     = empty ? '0 : mem[rd_ptr_reg];
    assign count       = count_reg;
    assign overflow    = overflow_reg;
    assign timeout_err = timeout_err_reg;
endmodule
